// File: rtl/mem_pkg.sv
// ---------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the MDR memory responder slice.
//   state_t        : responder FSM state encoding (IDLE/WAIT/ACCESS/DONE)
//   DEFAULT_DATA_W : default data word width (matches the MDR register)
//   DEFAULT_ADDR_W : default RAM address width (depth = 2**ADDR_W words)
//   COUNT_W        : width of the wait-state counter (WAIT_CYCLES is 0..15)
// ---------------------------------------------------------------------------
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 9;
    localparam int COUNT_W        = 4;

endpackage : mem_pkg

// File: rtl/ram_array.sv
// ---------------------------------------------------------------------------
// ram_array
// Single-port synchronous word RAM with a registered read port.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset of the read-data register only
//   en    : access enable for this cycle
//   we    : 1 = write wdata to addr, 0 = read addr into rdata
//   addr  : word address
//   wdata : write data
//   rdata : registered read data; holds its value between reads
// ---------------------------------------------------------------------------
module ram_array
    import mem_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Storage array has no reset so it maps onto block RAM and keeps its
    // contents across a responder reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register only updates on a read, so it holds the last read word
    // through writes and idle time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule : ram_array

// File: rtl/mdr_memory_responder.sv
// ---------------------------------------------------------------------------
// mdr_memory_responder
// Memory-side responder feeding the Mdatain leg of the MDR input mux.
// Accepts a Read or Write request addressed by MAR, waits WAIT_CYCLES
// cycles, performs one RAM access, then acknowledges with a four-phase
// mem_done handshake.
//   clk      : rising-edge clock
//   clr      : asynchronous active-low reset
//   Read     : read request level, held until mem_done is seen
//   Write    : write request level, held until mem_done is seen
//   MAR_out  : address from MAR; only the low ADDR_W bits are used
//   MDR_out  : write data from MDR
//   Mdatain  : read data to the MDR mux (holds last read value)
//   mem_done : transaction complete acknowledge
//   busy     : high whenever the FSM is not IDLE
//   err      : Read and Write were both high; sticky until next legal request
// ---------------------------------------------------------------------------
module mdr_memory_responder
    import mem_pkg::*;
#(
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int ADDR_W      = DEFAULT_ADDR_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              Read,
    input  logic              Write,
    input  logic [31:0]       MAR_out,
    input  logic [DATA_W-1:0] MDR_out,
    output logic [DATA_W-1:0] Mdatain,
    output logic              mem_done,
    output logic              busy,
    output logic              err
);

    localparam logic [COUNT_W-1:0] WAIT_INIT = COUNT_W'(WAIT_CYCLES);

    state_t               state;
    logic [COUNT_W-1:0]   count;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    data_q;
    logic                 op_write_q;
    logic                 ram_en;

    // Upper MAR bits are deliberately ignored so addresses wrap.
    logic unused_mar_bits;
    assign unused_mar_bits = ^MAR_out[31:ADDR_W];

    // The RAM is touched only during the single ACCESS cycle, using the
    // latched address/data/op so later input changes cannot leak in.
    assign ram_en = (state == ACCESS);

    ram_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .rst_n (clr),
        .en    (ram_en),
        .we    (op_write_q),
        .addr  (addr_q),
        .wdata (data_q),
        .rdata (Mdatain)
    );

    // Control FSM. mem_done and busy are registered alongside the state
    // transition so they line up exactly with the state they describe.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state      <= IDLE;
            count      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            op_write_q <= 1'b0;
            mem_done   <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Read ^ Write) begin
                        addr_q     <= MAR_out[ADDR_W-1:0];
                        data_q     <= MDR_out;
                        op_write_q <= Write;
                        err        <= 1'b0;
                        busy       <= 1'b1;
                        if (WAIT_CYCLES == 0) begin
                            state <= ACCESS;
                        end else begin
                            state <= WAIT;
                            count <= WAIT_INIT;
                        end
                    end else if (Read && Write) begin
                        err      <= 1'b1;
                        busy     <= 1'b1;
                        mem_done <= 1'b1;
                        state    <= DONE;
                    end
                end

                // Counter was loaded with WAIT_CYCLES, so leaving at 1
                // makes WAIT last exactly WAIT_CYCLES cycles.
                WAIT: begin
                    count <= count - 1'b1;
                    if (count == 1) begin
                        state <= ACCESS;
                    end
                end

                ACCESS: begin
                    mem_done <= 1'b1;
                    state    <= DONE;
                end

                // Four-phase completion: wait for the requester to drop
                // both request lines before returning to IDLE.
                DONE: begin
                    if (!(Read || Write)) begin
                        mem_done <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    mem_done <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule : mdr_memory_responder

// File: tb/tb_mdr_memory_responder.sv
// ---------------------------------------------------------------------------
// tb_mdr_memory_responder
// Directed bench for mdr_memory_responder: a WAIT_CYCLES=2 instance (dut)
// and a WAIT_CYCLES=0 instance (dut0) sharing clock and reset.
// ---------------------------------------------------------------------------
module tb_mdr_memory_responder;

    logic        clk;
    logic        clr;

    logic        rd, wr;
    logic [31:0] mar, mdr;
    logic [31:0] mdatain;
    logic        mem_done, busy, err;

    logic        rd0, wr0;
    logic [31:0] mar0, mdr0;
    logic [31:0] mdatain0;
    logic        mem_done0, busy0, err0;

    int vectors_applied = 0;
    int miscompares     = 0;

    mdr_memory_responder #(
        .DATA_W      (32),
        .ADDR_W      (9),
        .WAIT_CYCLES (2)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .Read     (rd),
        .Write    (wr),
        .MAR_out  (mar),
        .MDR_out  (mdr),
        .Mdatain  (mdatain),
        .mem_done (mem_done),
        .busy     (busy),
        .err      (err)
    );

    mdr_memory_responder #(
        .DATA_W      (32),
        .ADDR_W      (9),
        .WAIT_CYCLES (0)
    ) dut0 (
        .clk      (clk),
        .clr      (clr),
        .Read     (rd0),
        .Write    (wr0),
        .MAR_out  (mar0),
        .MDR_out  (mdr0),
        .Mdatain  (mdatain0),
        .mem_done (mem_done0),
        .busy     (busy0),
        .err      (err0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic w,
                                 input logic [31:0] a, input logic [31:0] d);
        rd  = r;
        wr  = w;
        mar = a;
        mdr = d;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors_applied++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h",
                   tag, observed, expected);
        end
    endtask

    // Full transaction on dut: request, 3 edges to mem_done, release, 1 edge.
    task automatic runTxn(input string tag, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
        applyStimulus(r, w, a, d);
        repeat (3) tick();
        tick();
        checkOutput({tag, "_done"}, 32'(mem_done), 32'd1);
        applyStimulus(1'b0, 1'b0, a, d);
        tick();
    endtask

    initial begin
        clr = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        rd0 = 1'b0; wr0 = 1'b0; mar0 = 32'd0; mdr0 = 32'd0;

        // Reset state
        #12;
        checkOutput("rst_mdatain",  mdatain,          32'd0);
        checkOutput("rst_done",     32'(mem_done),    32'd0);
        checkOutput("rst_busy",     32'(busy),        32'd0);
        checkOutput("rst_err",      32'(err),         32'd0);
        clr = 1'b1;
        tick();

        // Write 420 to address 5, step by step
        applyStimulus(1'b0, 1'b1, 32'd5, 32'd420);
        tick();
        checkOutput("wr_k_busy",    32'(busy),        32'd1);
        checkOutput("wr_k_done",    32'(mem_done),    32'd0);
        tick();
        checkOutput("wr_k1_done",   32'(mem_done),    32'd0);
        tick();
        checkOutput("wr_k2_done",   32'(mem_done),    32'd0);
        tick();
        checkOutput("wr_k3_done",   32'(mem_done),    32'd1);
        checkOutput("wr_mdatain",   mdatain,          32'd0);
        applyStimulus(1'b0, 1'b0, 32'd5, 32'd420);
        tick();
        checkOutput("wr_rel_done",  32'(mem_done),    32'd0);
        checkOutput("wr_rel_busy",  32'(busy),        32'd0);

        // Read back address 5
        applyStimulus(1'b1, 1'b0, 32'd5, 32'd0);
        tick();
        tick();
        tick();
        checkOutput("rd_k2_done",   32'(mem_done),    32'd0);
        checkOutput("rd_k2_data",   mdatain,          32'd0);
        tick();
        checkOutput("rd_k3_done",   32'(mem_done),    32'd1);
        checkOutput("rd_k3_data",   mdatain,          32'd420);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        tick();

        // Initialise address 7 to 0, then abort a write of 69 during WAIT
        runTxn("init7", 1'b0, 1'b1, 32'd7, 32'd0);
        runTxn("rd5a",  1'b1, 1'b0, 32'd5, 32'd0);
        checkOutput("rd5a_data",    mdatain,          32'd420);
        applyStimulus(1'b0, 1'b1, 32'd7, 32'd69);
        tick();
        tick();
        clr = 1'b0;
        #1;
        checkOutput("abort_mdatain", mdatain,         32'd0);
        checkOutput("abort_done",   32'(mem_done),    32'd0);
        checkOutput("abort_busy",   32'(busy),        32'd0);
        checkOutput("abort_err",    32'(err),         32'd0);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        #2;
        clr = 1'b1;
        tick();
        runTxn("rd5b", 1'b1, 1'b0, 32'd5, 32'd0);
        checkOutput("rd5b_data",    mdatain,          32'd420);
        runTxn("rd7",  1'b1, 1'b0, 32'd7, 32'd0);
        checkOutput("rd7_data",     mdatain,          32'd0);

        // Illegal request
        runTxn("rd5c", 1'b1, 1'b0, 32'd5, 32'd0);
        applyStimulus(1'b1, 1'b1, 32'd5, 32'hFFFF_FFFF);
        tick();
        checkOutput("ill_err",      32'(err),         32'd1);
        checkOutput("ill_done",     32'(mem_done),    32'd1);
        checkOutput("ill_busy",     32'(busy),        32'd1);
        checkOutput("ill_mdatain",  mdatain,          32'd420);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        checkOutput("ill_rel_done", 32'(mem_done),    32'd0);
        checkOutput("ill_rel_busy", 32'(busy),        32'd0);
        checkOutput("ill_rel_err",  32'(err),         32'd1);
        applyStimulus(1'b1, 1'b0, 32'd7, 32'd0);
        tick();
        checkOutput("ill_clr_err",  32'(err),         32'd0);
        tick();
        tick();
        tick();
        checkOutput("hold_done0",   32'(mem_done),    32'd1);
        checkOutput("hold_data0",   mdatain,          32'd0);

        // Handshake hold: Read kept high for 5 more cycles
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput($sformatf("hold_done%0d", i + 1), 32'(mem_done), 32'd1);
            checkOutput($sformatf("hold_busy%0d", i + 1), 32'(busy),     32'd1);
        end
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        checkOutput("hold_rel_done", 32'(mem_done),   32'd0);
        checkOutput("hold_rel_busy", 32'(busy),       32'd0);

        // Address wrap and input isolation
        applyStimulus(1'b0, 1'b1, 32'h0000_0205, 32'hDEAD_BEEF);
        tick();
        applyStimulus(1'b0, 1'b1, 32'd9, 32'd0);
        tick();
        tick();
        tick();
        checkOutput("wrap_done",    32'(mem_done),    32'd1);
        applyStimulus(1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        runTxn("wrap_rd", 1'b1, 1'b0, 32'd5, 32'd0);
        checkOutput("wrap_data",    mdatain,          32'hDEAD_BEEF);
        runTxn("rd9", 1'b1, 1'b0, 32'd9, 32'd0);
        checkOutput("rd9_data",     mdatain,          32'd0);

        // WAIT_CYCLES=0 instance: write 69 to address 3, then read it
        rd0 = 1'b0; wr0 = 1'b1; mar0 = 32'd3; mdr0 = 32'd69;
        tick();
        checkOutput("z_wr_k_done",  32'(mem_done0),   32'd0);
        checkOutput("z_wr_k_busy",  32'(busy0),       32'd1);
        tick();
        checkOutput("z_wr_k1_done", 32'(mem_done0),   32'd1);
        wr0 = 1'b0;
        tick();
        checkOutput("z_rel_busy",   32'(busy0),       32'd0);
        rd0 = 1'b1; mar0 = 32'd3; mdr0 = 32'd0;
        tick();
        checkOutput("z_rd_k_done",  32'(mem_done0),   32'd0);
        tick();
        checkOutput("z_rd_k1_done", 32'(mem_done0),   32'd1);
        checkOutput("z_rd_k1_data", mdatain0,         32'd69);
        rd0 = 1'b0;
        tick();
        checkOutput("z_rd_rel_done", 32'(mem_done0),  32'd0);

        $display("[TB] directed sequence complete");
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors_applied, miscompares);
        $finish;
    end

endmodule : tb_mdr_memory_responder
